// File: rtl/ami_copy_initiator_pkg.sv
// AMI bus widths and request/response layout, plus the copy engine's shared types.
// The AMI_* macros are the shared bus definitions; the package mirrors them as localparams.
`ifndef AMI_TYPES_DEFINED
`define AMI_TYPES_DEFINED
`define AMI_ADDR_WIDTH 64
`define AMI_DATA_WIDTH 512
`define AMI_REQ_SIZE_WIDTH 64
`define AMI_REQUEST_BUS_WIDTH (2 + `AMI_ADDR_WIDTH + `AMI_DATA_WIDTH + `AMI_REQ_SIZE_WIDTH)
`define AMI_RESPONSE_BUS_WIDTH (1 + `AMI_DATA_WIDTH + `AMI_REQ_SIZE_WIDTH)
`endif

package ami_copy_initiator_pkg;

    localparam int AMI_ADDR_W = `AMI_ADDR_WIDTH;
    localparam int AMI_DATA_W = `AMI_DATA_WIDTH;
    localparam int AMI_SIZE_W = `AMI_REQ_SIZE_WIDTH;
    localparam int AMI_REQ_W  = `AMI_REQUEST_BUS_WIDTH;
    localparam int AMI_RESP_W = `AMI_RESPONSE_BUS_WIDTH;

    localparam int unsigned DEF_BLOCK_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } copy_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [AMI_ADDR_W-1:0] addr;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } ami_req_t;

    typedef struct packed {
        logic                  valid;
        logic [AMI_DATA_W-1:0] data;
        logic [AMI_SIZE_W-1:0] size;
    } ami_resp_t;

    // An idle request is driven as all zeros so the bus carries no stale fields.
    function automatic ami_req_t ami_mk_req(
        input logic                  vld,
        input logic                  wr,
        input logic [AMI_ADDR_W-1:0] addr,
        input logic [AMI_DATA_W-1:0] data,
        input int unsigned           bytes
    );
        ami_req_t r;
        r = '0;
        if (vld) begin
            r.valid    = 1'b1;
            r.is_write = wr;
            r.addr     = addr;
            r.data     = data;
            r.size     = AMI_SIZE_W'(bytes);
        end
        return r;
    endfunction

endpackage

// File: rtl/ami_copy_fifo.sv
// Synchronous read-data buffer for the copy engine; head is the oldest entry.
module ami_copy_fifo
    import ami_copy_initiator_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = AMI_DATA_W,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ami_copy_initiator.sv
// Block copy engine: streams num_blocks reads from src_addr into a credit-limited buffer
// and writes them back out at dst_addr. Define AMI_COPY_STATS_EN for busy/stall counters.
module ami_copy_initiator
    import ami_copy_initiator_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
    parameter int          CNT_W       = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [`AMI_ADDR_WIDTH-1:0]         src_addr,
    input  logic [`AMI_ADDR_WIDTH-1:0]         dst_addr,
    input  logic [CNT_W-1:0]                   num_blocks,
    output logic                               busy,
    output logic                               done,
    output logic [`AMI_REQUEST_BUS_WIDTH-1:0]  mem_req0,
    input  logic                               mem_req0_grant,
    input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0] mem_resp0,
    output logic                               mem_resp0_grant,
    output logic [`AMI_REQUEST_BUS_WIDTH-1:0]  mem_req1,
    input  logic                               mem_req1_grant,
    input  logic [`AMI_RESPONSE_BUS_WIDTH-1:0] mem_resp1,
    output logic                               mem_resp1_grant
`ifdef AMI_COPY_STATS_EN
    ,
    output logic [31:0]                        busy_cycles,
    output logic [31:0]                        rd_stall_cycles
`endif
);

    localparam int                    CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]           CREDITS = (CW+1)'(FIFO_DEPTH);
    localparam logic [AMI_ADDR_W-1:0] STRIDE  = AMI_ADDR_W'(BLOCK_BYTES);

    copy_state_t           state;
    logic [AMI_ADDR_W-1:0] rd_addr;
    logic [AMI_ADDR_W-1:0] wr_addr;
    logic [CNT_W-1:0]      n_blk;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         fifo_cnt;
    logic [CW:0]           credit_used;
    logic [AMI_DATA_W-1:0] fifo_head;
    ami_resp_t             resp0;
    logic                  rd_vld, wr_vld, rd_fire, wr_fire, push, resp_ret;
    logic                  unused_bits;

    assign resp0       = mem_resp0;
    assign unused_bits = ^{mem_resp1, resp0.size};

    // Reads in flight plus buffered data never exceed the buffer, so every response has a slot.
    assign credit_used = {1'b0, outst} + {1'b0, fifo_cnt};
    assign rd_vld      = (state == ST_RUN) && (rd_cnt < n_blk) && (credit_used < CREDITS);
    assign wr_vld      = (state == ST_RUN) && (fifo_cnt != '0);
    assign rd_fire     = rd_vld && mem_req0_grant;
    assign wr_fire     = wr_vld && mem_req1_grant;
    assign push        = (state == ST_RUN) && resp0.valid;
    // Responses left over from an aborted copy arrive with nothing outstanding.
    assign resp_ret    = resp0.valid && (outst != '0);

    assign mem_resp0_grant = resp0.valid;
    assign mem_resp1_grant = 1'b1;
    assign mem_req0 = ami_mk_req(rd_vld, 1'b0, rd_addr, '0, BLOCK_BYTES);
    assign mem_req1 = ami_mk_req(wr_vld, 1'b1, wr_addr, fifo_head, BLOCK_BYTES);

    ami_copy_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AMI_DATA_W),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (resp0.data),
        .pop       (wr_fire),
        .head      (fifo_head),
        .count     (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            n_blk   <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            outst   <= '0;
        end else begin
            case ({rd_fire, resp_ret})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: ;
            endcase
            case (state)
                ST_IDLE: if (start) begin
                    rd_addr <= src_addr;
                    wr_addr <= dst_addr;
                    n_blk   <= num_blocks;
                    rd_cnt  <= '0;
                    wr_cnt  <= '0;
                    busy    <= 1'b1;
                    if (num_blocks == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rd_fire) begin
                        rd_addr <= rd_addr + STRIDE;
                        rd_cnt  <= rd_cnt + CNT_W'(1);
                    end
                    if (wr_fire) begin
                        wr_addr <= wr_addr + STRIDE;
                        wr_cnt  <= wr_cnt + CNT_W'(1);
                    end
                    if (wr_cnt == n_blk) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AMI_COPY_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE && start)) begin
            busy_cycles     <= '0;
            rd_stall_cycles <= '0;
        end else begin
            if (busy && busy_cycles != '1)
                busy_cycles <= busy_cycles + 32'd1;
            if (rd_vld && !mem_req0_grant && rd_stall_cycles != '1)
                rd_stall_cycles <= rd_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
